// File: rtl/reset_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module  : reset_sequencer_pkg
// Brief   : Shared types and helpers for the staggered reset sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    HOLD    = 2'd1,
    STAGGER = 2'd2,
    DONE    = 2'd3
  } seq_state_t;

  typedef enum logic {
    CAUSE_ASYNC = 1'b0,
    CAUSE_SW    = 1'b1
  } rst_cause_t;

  localparam int         c_SW_CNT_W   = 8;
  localparam logic [7:0] c_SW_CNT_MAX = 8'd255;

  // Width that holds max_val with one bit of headroom.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sync_chain.sv
//------------------------------------------------------------------------------
// Module  : reset_sync_chain
// Brief   : Async-clear, sync-set flop chain; sync_out rises STAGES edges after release.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reset_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic async_reset,
  output logic sync_out
);

  logic [STAGES-1:0] r_sync;

  generate
    if (STAGES == 1) begin : g_single
      always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
          r_sync <= 1'b0;
        end else begin
          r_sync <= 1'b1;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[STAGES-2:0], 1'b1};
        end
      end
    end
  endgenerate

  assign sync_out = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
//------------------------------------------------------------------------------
// Module  : reset_sequencer
// Brief   : Async-assert reset generator with synchronised release and staggered
//           per-domain deassertion. Optional status ports: RESET_SEQUENCER_STATUS_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int   SYNC_STAGES    = 3,
  parameter int   NUM_OUT        = 4,
  parameter int   HOLD_CYCLES    = 16,
  parameter int   STAGGER_CYCLES = 8,
  parameter logic OUT_POLARITY   = 1'b1
) (
  input  logic               clk,
  input  logic               async_reset,
  input  logic               sw_reset_req,
`ifdef RESET_SEQUENCER_STATUS_EN
  output logic               reset_cause,
  output logic [7:0]         sw_reset_count,
`endif
  output logic [NUM_OUT-1:0] rst_o,
  output logic               rst_done
);

  localparam int c_HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int c_STAG_W = cnt_width(STAGGER_CYCLES);
  localparam int c_IDX_W  = cnt_width(NUM_OUT);

  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [c_STAG_W-1:0] c_STAG_LAST = c_STAG_W'(STAGGER_CYCLES - 1);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(NUM_OUT - 1);

  seq_state_t          r_state, w_state_d;
  logic [c_HOLD_W-1:0] r_hold, w_hold_d;
  logic [c_STAG_W-1:0] r_stag, w_stag_d;
  logic [c_IDX_W-1:0]  r_idx, w_idx_d, w_idx_inc;
  logic [NUM_OUT-1:0]  r_rst, w_rst_d, w_rst_shift;
  logic                r_done, w_done_d;
  logic                w_sync_out;

  // The SYNC->HOLD state flop is the last synchroniser stage, so the chain
  // is one shorter and HOLD is entered exactly SYNC_STAGES edges after release.
  reset_sync_chain #(
    .STAGES(SYNC_STAGES - 1)
  ) u_sync (
    .clk        (clk),
    .async_reset(async_reset),
    .sync_out   (w_sync_out)
  );

  // Shifting zeros in from bit 0 releases outputs strictly in index order.
  assign w_rst_shift = r_rst << 1;
  assign w_idx_inc   = r_idx + 1'b1;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      r_state <= SYNC;
      r_hold  <= '0;
      r_stag  <= '0;
      r_idx   <= '0;
      r_rst   <= '1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_hold  <= w_hold_d;
      r_stag  <= w_stag_d;
      r_idx   <= w_idx_d;
      r_rst   <= w_rst_d;
      r_done  <= w_done_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_hold_d  = r_hold;
    w_stag_d  = r_stag;
    w_idx_d   = r_idx;
    w_rst_d   = r_rst;
    w_done_d  = r_done;
    case (r_state)
      SYNC: begin
        if (w_sync_out) begin
          w_state_d = HOLD;
          w_hold_d  = '0;
        end
      end
      HOLD: begin
        if (r_hold == c_HOLD_LAST) begin
          w_rst_d   = w_rst_shift;
          w_idx_d   = '0;
          w_stag_d  = '0;
          w_hold_d  = '0;
          w_state_d = (NUM_OUT == 1) ? DONE : STAGGER;
          w_done_d  = (NUM_OUT == 1);
        end else begin
          w_hold_d = r_hold + 1'b1;
        end
      end
      STAGGER: begin
        if (r_stag == c_STAG_LAST) begin
          w_rst_d  = w_rst_shift;
          w_idx_d  = w_idx_inc;
          w_stag_d = '0;
          if (w_idx_inc == c_IDX_LAST) begin
            w_state_d = DONE;
            w_done_d  = 1'b1;
          end
        end else begin
          w_stag_d = r_stag + 1'b1;
        end
      end
      DONE: begin
        if (sw_reset_req) begin
          w_rst_d   = '1;
          w_done_d  = 1'b0;
          w_hold_d  = '0;
          w_state_d = HOLD;
        end
      end
      default: begin
        w_state_d = SYNC;
      end
    endcase
  end

  // Stored active-high; flip to the configured asserted level at the pins.
  assign rst_o    = r_rst ^ {NUM_OUT{~OUT_POLARITY}};
  assign rst_done = r_done;

`ifdef RESET_SEQUENCER_STATUS_EN
  logic       w_sw_accept;
  rst_cause_t r_cause;
  logic [7:0] r_sw_cnt;

  assign w_sw_accept = (r_state == DONE) && sw_reset_req;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      r_cause  <= CAUSE_ASYNC;
      r_sw_cnt <= '0;
    end else if (w_sw_accept) begin
      r_cause <= CAUSE_SW;
      if (r_sw_cnt != c_SW_CNT_MAX) begin
        r_sw_cnt <= r_sw_cnt + 1'b1;
      end
    end
  end

  assign reset_cause    = r_cause;
  assign sw_reset_count = r_sw_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_reset_sequencer
// Brief   : Directed bench for reset_sequencer (default and minimal configurations).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reset_sequencer;

  logic       clk;
  logic       async_reset;
  logic       sw_reset_req;
  logic       sw_min;
  logic [3:0] rst_o;
  logic       rst_done;
  logic [0:0] rst_min;
  logic       done_min;
`ifdef RESET_SEQUENCER_STATUS_EN
  logic       reset_cause, cause_min;
  logic [7:0] sw_reset_count, count_min;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int edge_n   = 0;

  reset_sequencer u_dut (
    .clk           (clk),
    .async_reset   (async_reset),
    .sw_reset_req  (sw_reset_req),
`ifdef RESET_SEQUENCER_STATUS_EN
    .reset_cause   (reset_cause),
    .sw_reset_count(sw_reset_count),
`endif
    .rst_o         (rst_o),
    .rst_done      (rst_done)
  );

  reset_sequencer #(
    .SYNC_STAGES (2),
    .NUM_OUT     (1),
    .HOLD_CYCLES (1),
    .OUT_POLARITY(1'b0)
  ) u_dut_min (
    .clk           (clk),
    .async_reset   (async_reset),
    .sw_reset_req  (sw_min),
`ifdef RESET_SEQUENCER_STATUS_EN
    .reset_cause   (cause_min),
    .sw_reset_count(count_min),
`endif
    .rst_o         (rst_min),
    .rst_done      (done_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic step_to(input int target);
    while (edge_n < target) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic check_main(input string tag, input logic [3:0] exp_rst, input logic exp_done);
    check_eq({tag, "_rst"}, {28'd0, rst_o}, {28'd0, exp_rst});
    check_eq({tag, "_done"}, {31'd0, rst_done}, {31'd0, exp_done});
  endtask

  // Hold async_reset low for a few cycles, then release just after an edge (edge 0).
  task automatic pulse_async_reset();
    async_reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    async_reset = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    async_reset  = 1'b1;
    sw_reset_req = 1'b0;
    sw_min       = 1'b0;
    #2;
    async_reset = 1'b0;
    #1;
    check_main("por_async", 4'hF, 1'b0);
    check_eq("por_min_rst", {31'd0, rst_min}, 32'd0);
    check_eq("por_min_done", {31'd0, done_min}, 32'd0);
`ifdef RESET_SEQUENCER_STATUS_EN
    check_eq("por_cause", {31'd0, reset_cause}, 32'd0);
    check_eq("por_count", {24'd0, sw_reset_count}, 32'd0);
`endif
    repeat (5) @(posedge clk);
    #1;
    check_main("por_held", 4'hF, 1'b0);
    async_reset = 1'b1;
    edge_n = 0;

    // Power-on sequence with both configurations running side by side.
    step_to(2);
    check_eq("min_e2_rst", {31'd0, rst_min}, 32'd0);
    check_eq("min_e2_done", {31'd0, done_min}, 32'd0);
    step_to(3);
    check_eq("min_e3_rst", {31'd0, rst_min}, 32'd1);
    check_eq("min_e3_done", {31'd0, done_min}, 32'd1);
    step_to(18); check_main("t1_e18", 4'hF, 1'b0);
    step_to(19); check_main("t1_e19", 4'hE, 1'b0);
    step_to(26); check_main("t1_e26", 4'hE, 1'b0);
    step_to(27); check_main("t1_e27", 4'hC, 1'b0);
    step_to(34); check_main("t1_e34", 4'hC, 1'b0);
    step_to(35); check_main("t1_e35", 4'h8, 1'b0);
    step_to(42); check_main("t1_e42", 4'h8, 1'b0);
    step_to(43); check_main("t1_e43", 4'h0, 1'b1);
    step_to(50); check_main("t1_e50", 4'h0, 1'b1);

    // Abort mid-STAGGER without a clock edge, then a full restart.
    pulse_async_reset();
    step_to(30); check_main("t2_e30", 4'hC, 1'b0);
    async_reset = 1'b0;
    #1;
    check_main("t2_abort", 4'hF, 1'b0);
    check_eq("t2_min_abort", {31'd0, rst_min}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    async_reset = 1'b1;
    edge_n = 0;
    step_to(3);  check_eq("t2_min_e3", {31'd0, rst_min}, 32'd1);
    step_to(18); check_main("t2_e18", 4'hF, 1'b0);
    step_to(19); check_main("t2_e19", 4'hE, 1'b0);
    step_to(35); check_main("t2_e35", 4'h8, 1'b0);
    step_to(43); check_main("t2_e43", 4'h0, 1'b1);

    // Software reset pulse at edge 50; a held request from edge 60 must wait for DONE.
    step_to(49);
    sw_reset_req = 1'b1;
    step_to(50);
    sw_reset_req = 1'b0;
    check_main("t3_e50", 4'hF, 1'b0);
`ifdef RESET_SEQUENCER_STATUS_EN
    check_eq("t3_cause", {31'd0, reset_cause}, 32'd1);
    check_eq("t3_count", {24'd0, sw_reset_count}, 32'd1);
`endif
    step_to(60);
    sw_reset_req = 1'b1;
    step_to(65); check_main("t3_e65", 4'hF, 1'b0);
    step_to(66); check_main("t4_e66", 4'hE, 1'b0);
    step_to(89); check_main("t3_e89", 4'h8, 1'b0);
    step_to(90); check_main("t3_e90", 4'h0, 1'b1);
    step_to(91); check_main("t4_e91", 4'hF, 1'b0);
    sw_reset_req = 1'b0;
`ifdef RESET_SEQUENCER_STATUS_EN
    check_eq("t4_count", {24'd0, sw_reset_count}, 32'd2);
`endif
    step_to(106); check_main("t4_e106", 4'hF, 1'b0);
    step_to(107); check_main("t4_e107", 4'hE, 1'b0);
    step_to(131); check_main("t4_e131", 4'h0, 1'b1);

`ifdef RESET_SEQUENCER_STATUS_EN
    // Continuous request: one accept every 41 edges starting at edge 132.
    sw_reset_req = 1'b1;
    step_to(132);
    check_eq("t6_count_3", {24'd0, sw_reset_count}, 32'd3);
    step_to(10463);
    check_eq("t6_count_254", {24'd0, sw_reset_count}, 32'd254);
    step_to(10464);
    check_eq("t6_count_255", {24'd0, sw_reset_count}, 32'd255);
    step_to(12309);
    check_eq("t6_count_sat", {24'd0, sw_reset_count}, 32'd255);
    check_eq("t6_cause_sw", {31'd0, reset_cause}, 32'd1);
    check_main("t6_e12309", 4'hF, 1'b0);
    sw_reset_req = 1'b0;
    async_reset  = 1'b0;
    #1;
    check_eq("t6_count_clr", {24'd0, sw_reset_count}, 32'd0);
    check_eq("t6_cause_clr", {31'd0, reset_cause}, 32'd0);
    async_reset = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
